bit_string_printer: RTL and testbench
=====================================

# bit_string_printer

Parametrised successor to the single-word bit printer. It collects NUM_BITS ASCII '0'/'1' characters from the UART receive path into a word. It then transmits that word back as ASCII characters through the UART transmit handshake, in receive order or bit-reversed, selectable at run time. It sits between the UART rx/tx cores and also exposes the captured word to downstream logic.

## Interface
- NUM_BITS, 8: characters per word; legal range 1..32.
- CW, $clog2(NUM_BITS+1): width of the count/index registers; derived, not overridden.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rx_data  in  8  received character; valid only while new_rx_data=1.
- new_rx_data  in  1  one-cycle strobe from the UART rx core.
- tx_busy  in  1  UART tx core busy; a transmit request is made only when this is low.
- reverse  in  1  print order; 0 prints in receive order, 1 prints bit-reversed; sampled once per word.
- tx_data  out  8  character to transmit; 8'h00 outside SEND.
- new_tx_data  out  1  transmit strobe, one cycle per character.
- word  out  NUM_BITS  last completed word; first received character lands in the MSB.
- word_valid  out  1  one-cycle pulse when a word completes.
- rx_drop  out  1  one-cycle pulse when a character arrives outside COLLECT.
- state  out  2  debug state: 0=COLLECT, 1=SEND, 2=HOLD.
- count  out  CW  bits collected (in COLLECT) or characters sent (in SEND/HOLD).

## Operation
- On reset:
  - state=COLLECT and count=0.
  - The shift register, word and the latched reverse flag are all 0.
  - tx_data=0, new_tx_data=0, word_valid=0, rx_drop=0.
- COLLECT, receiving a digit (new_rx_data=1 and rx_data is 8'h30 or 8'h31):
  - The bit shifts into the LSB of the shift register; earlier bits move toward the MSB.
  - count increments.
- COLLECT, receiving any other character: ignored, no flag.
- Word completion, when count would reach NUM_BITS:
  - word is loaded with the full shift register.
  - word_valid pulses.
  - reverse is latched.
  - count clears to 0 and the state goes to SEND.
- SEND:
  - new_tx_data = !tx_busy (combinational).
  - tx_data = 8'h30 + selected bit.
  - The selected bit is word[NUM_BITS-1-count] when latched reverse=0, and word[count] when latched reverse=1.
  - On a cycle with new_tx_data=1, count increments and the state goes to HOLD.
- HOLD:
  - Lasts exactly one cycle so that the tx core's tx_busy can assert.
  - Returns to SEND if count<NUM_BITS; otherwise the final step follows the Configuration section.
- A new_rx_data strobe while in SEND or HOLD is discarded and pulses rx_drop. The shift register is untouched.
- Reset in any state, including mid-print, returns to COLLECT immediately. Partially collected bits and a pending print are lost.

## Timing
- A digit strobe in cycle t updates the shift register and count at edge t+1.
- The strobe carrying the Nth digit gives word, word_valid=1 and state=SEND in cycle t+1. word_valid is 0 again in t+2.
- The first new_tx_data can appear in cycle t+1 if tx_busy=0.
- With tx_busy held low, characters go out every 2 cycles. A full word takes 2*NUM_BITS cycles (plus 4 with CRLF).
- tx_data is stable for the whole cycle in which new_tx_data=1.
- new_tx_data is never high in two consecutive cycles.
- Changing reverse in the middle of a print has no effect until the next word.

## Configuration
- BITSTR_CRLF_EN defined:
  - After the HOLD of the last bit, the block sends 8'h0D then 8'h0A. Each uses the same SEND/HOLD handshake, with count values NUM_BITS and NUM_BITS+1.
  - The block then returns to COLLECT with count=0.
  - CW widens to $clog2(NUM_BITS+3).
- BITSTR_CRLF_EN undefined: the block returns to COLLECT straight from the HOLD of the last bit.

## Test plan
- Receive-order print: NUM_BITS=8, reverse=0, tx_busy=0, send "10110010".
  - word=8'hB2 with one word_valid pulse.
  - tx sequence "10110010"; 8 strobes, 2 cycles apart.
- Reversed print: reverse=1, send "11100000".
  - word=8'hE0.
  - tx sequence "00000111".
- Filtering and drops:
  - Interleave 'a', 8'h0D and '2' between the digits; they are ignored and the word is unchanged.
  - Inject rx strobes during SEND; each gives an rx_drop pulse and the printed output is unchanged.
- tx_busy backpressure: hold tx_busy=1 for 20 cycles after each strobe.
  - new_tx_data stays low while busy.
  - Each character is sent exactly once, in the correct order.
- Reset mid-operation:
  - Assert rst after 5 digits: count=0, state=0.
  - Assert rst after the 3rd tx strobe: no further strobes.
  - The next 8 digits then print normally.
- CRLF and edge width: with BITSTR_CRLF_EN defined and NUM_BITS=1, send "1".
  - tx sequence 8'h31, 8'h0D, 8'h0A.
  - Block returns to COLLECT.

Source files
------------

// File: rtl/bit_string_printer.sv
// Collects NUM_BITS ASCII '0'/'1' characters into a word and prints it back over the UART tx handshake.
// Define BITSTR_CRLF_EN to append CR LF after every printed word.
module bit_string_printer #(
  parameter int NUM_BITS = 8,
`ifdef BITSTR_CRLF_EN
  parameter int CW = $clog2(NUM_BITS + 3)
`else
  parameter int CW = $clog2(NUM_BITS + 1)
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                new_rx_data,
  input  logic                tx_busy,
  input  logic                reverse,
  output logic [7:0]          tx_data,
  output logic                new_tx_data,
  output logic [NUM_BITS-1:0] word,
  output logic                word_valid,
  output logic                rx_drop,
  output logic [1:0]          state,
  output logic [CW-1:0]       count
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SEND    = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);
  localparam logic [CW-1:0] BITS_END = CW'(NUM_BITS);
  localparam logic [CW-1:0] ONE      = CW'(1);
`ifdef BITSTR_CRLF_EN
  localparam logic [CW-1:0] SEQ_END  = CW'(NUM_BITS + 2);
`else
  localparam logic [CW-1:0] SEQ_END  = BITS_END;
`endif

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [NUM_BITS-1:0] word_q, word_d;
  logic                rev_q, rev_d;
  logic                wv_q, wv_d;
  logic                drop_q, drop_d;
  logic                is_digit;
  logic                cur_bit;

  assign is_digit = (rx_data[7:1] == 7'b0011000);

  // Bit under the print cursor; the latched order decides which end count walks from.
  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (count_q == CW'(i)) begin
        cur_bit = rev_q ? word_q[i] : word_q[NUM_BITS-1-i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    word_d      = word_q;
    rev_d       = rev_q;
    wv_d        = 1'b0;
    drop_d      = 1'b0;
    tx_data     = 8'h00;
    new_tx_data = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (new_rx_data && is_digit) begin
          shift_d = (shift_q << 1) | NUM_BITS'(rx_data[0]);
          if (count_q == LAST_BIT) begin
            word_d  = shift_d;
            wv_d    = 1'b1;
            rev_d   = reverse;
            count_d = '0;
            state_d = SEND;
          end else begin
            count_d = count_q + ONE;
          end
        end
      end
      SEND: begin
        drop_d      = new_rx_data;
        new_tx_data = !tx_busy;
        if (count_q < BITS_END) begin
          tx_data = {7'b0011000, cur_bit};
`ifdef BITSTR_CRLF_EN
        end else if (count_q == BITS_END) begin
          tx_data = 8'h0D;
        end else begin
          tx_data = 8'h0A;
`endif
        end
        if (!tx_busy) begin
          count_d = count_q + ONE;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // One idle cycle gives the tx core time to raise tx_busy.
        drop_d = new_rx_data;
        if (count_q < SEQ_END) begin
          state_d = SEND;
        end else begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      count_q <= '0;
      shift_q <= '0;
      word_q  <= '0;
      rev_q   <= 1'b0;
      wv_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      rev_q   <= rev_d;
      wv_q    <= wv_d;
      drop_q  <= drop_d;
    end
  end

  assign word       = word_q;
  assign word_valid = wv_q;
  assign rx_drop    = drop_q;
  assign state      = state_q;
  assign count      = count_q;

endmodule

// File: tb/tb_bit_string_printer.sv
// Scoreboard bench for bit_string_printer: expected words and tx characters are queued as digits are
// driven and popped as the DUTs print. A NUM_BITS=1 instance covers the narrow edge case.
`timescale 1ns/1ps
module tb_bit_string_printer;

  localparam int NB = 8;
`ifdef BITSTR_CRLF_EN
  localparam int CW8   = $clog2(NB + 3);
  localparam int CW1   = $clog2(1 + 3);
  localparam int NTAIL = 2;
`else
  localparam int CW8   = $clog2(NB + 1);
  localparam int CW1   = $clog2(1 + 1);
  localparam int NTAIL = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     rx_data = 8'h00;
  logic           new_rx_data = 1'b0;
  logic           tx_busy = 1'b0;
  logic           reverse = 1'b0;
  logic [7:0]     tx_data;
  logic           new_tx_data;
  logic [NB-1:0]  word;
  logic           word_valid;
  logic           rx_drop;
  logic [1:0]     state;
  logic [CW8-1:0] count;

  logic [7:0]     rx_data1 = 8'h00;
  logic           new_rx_data1 = 1'b0;
  logic           tx_busy1 = 1'b0;
  logic           reverse1 = 1'b0;
  logic [7:0]     tx_data1;
  logic           new_tx_data1;
  logic [0:0]     word1;
  logic           word_valid1;
  logic           rx_drop1;
  logic [1:0]     state1;
  logic [CW1-1:0] count1;

  bit_string_printer #(.NUM_BITS(NB)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data), .tx_busy(tx_busy),
    .reverse(reverse), .tx_data(tx_data), .new_tx_data(new_tx_data), .word(word),
    .word_valid(word_valid), .rx_drop(rx_drop), .state(state), .count(count)
  );

  bit_string_printer #(.NUM_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data1), .new_rx_data(new_rx_data1), .tx_busy(tx_busy1),
    .reverse(reverse1), .tx_data(tx_data1), .new_tx_data(new_tx_data1), .word(word1),
    .word_valid(word_valid1), .rx_drop(rx_drop1), .state(state1), .count(count1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0]    exp_tx[$];
  logic [NB-1:0] exp_word[$];
  logic [7:0]    exp_tx1[$];
  int            tx_times[$];
  int            cycle = 0;
  int            wv_cycle = 0;
  int            tx_seen = 0;
  int            drop_seen = 0;
  int            exp_drops = 0;
  logic          prev_tx = 1'b0;
  logic          prev_wv = 1'b0;
  logic          bp_en = 1'b0;
  int            busy_cnt = 0;
  logic [NB-1:0] m_shift = '0;
  int            m_count = 0;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic pushWord(input logic [NB-1:0] w, input logic rev);
    exp_word.push_back(w);
    for (int i = 0; i < NB; i++) begin
      exp_tx.push_back(rev ? {7'b0011000, w[i]} : {7'b0011000, w[NB-1-i]});
    end
`ifdef BITSTR_CRLF_EN
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h0A);
`endif
  endtask

  task automatic sendChar(input logic [7:0] c);
    @(posedge clk); #1;
    rx_data = c;
    new_rx_data = 1'b1;
    @(posedge clk); #1;
    new_rx_data = 1'b0;
    rx_data = 8'h00;
  endtask

  // Drives a character string; digits feed the model, which queues the word once it is complete.
  task automatic applyStimulus(input string s, input logic rev);
    logic [7:0] c;
    logic       done;
    reverse = rev;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      done = 1'b0;
      sendChar(c);
      if (c == 8'h30 || c == 8'h31) begin
        m_shift = {m_shift[NB-2:0], c[0]};
        m_count++;
        if (m_count == NB) begin
          pushWord(m_shift, rev);
          m_count = 0;
          done = 1'b1;
        end
      end
      @(negedge clk);
      checkOutput("collect_count", count, m_count);
      checkOutput("collect_state", state, done ? 2'd1 : 2'd0);
    end
  endtask

  task automatic injectDrop(input logic [7:0] c);
    sendChar(c);
    exp_drops++;
    @(negedge clk);
    checkOutput("rx_drop", rx_drop, 1);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((exp_tx.size() != 0 || state != 2'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_left", exp_tx.size(), 0);
    checkOutput("drain_state", state, 0);
    checkOutput("drain_count", count, 0);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_tx.delete();
    exp_word.delete();
    m_shift = '0;
    m_count = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_word", word, 0);
    checkOutput("rst_flags", {word_valid, rx_drop, new_tx_data}, 0);
    checkOutput("rst_tx_data", tx_data, 0);
  endtask

  // Scoreboard side: every strobe and word pulse is matched against the queued expectations.
  always @(negedge clk) begin
    cycle++;
    if (!rst) begin
      if (new_tx_data) begin
        checkOutput("tx_while_busy", tx_busy, 0);
        checkOutput("tx_back_to_back", prev_tx, 0);
        if (exp_tx.size() == 0) checkOutput("tx_extra", exp_tx.size(), 1);
        else checkOutput("tx_char", tx_data, exp_tx.pop_front());
        tx_times.push_back(cycle);
        tx_seen++;
      end
      if (state == 2'd2) checkOutput("hold_idle", {new_tx_data, tx_data}, 0);
      if (word_valid) begin
        wv_cycle = cycle;
        checkOutput("wv_pulse", prev_wv, 0);
        checkOutput("wv_state", state, 1);
        if (exp_word.size() == 0) checkOutput("wv_extra", exp_word.size(), 1);
        else checkOutput("word", word, exp_word.pop_front());
      end
      if (rx_drop) drop_seen++;
      if (new_tx_data1) begin
        if (exp_tx1.size() == 0) checkOutput("tx1_extra", exp_tx1.size(), 1);
        else checkOutput("tx1_char", tx_data1, exp_tx1.pop_front());
      end
    end
    prev_tx = new_tx_data;
    prev_wv = word_valid;
  end

  // Stand-in for the tx core: stays busy for 20 cycles after each strobe while backpressure is on.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (busy_cnt > 0) busy_cnt--;
      if (bp_en && prev_tx) busy_cnt = 20;
      tx_busy = bp_en && (busy_cnt > 0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int saved;
    int n;
    repeat (3) @(posedge clk);
    doReset();
    checkOutput("rst_state1", state1, 0);

    $display("[TB] receive-order print");
    tx_times.delete();
    applyStimulus("10110010", 1'b0);
    waitDrain(100);
    checkOutput("tx_total", tx_times.size(), NB + NTAIL);
    if (tx_times.size() > 0) checkOutput("first_tx_cycle", tx_times[0], wv_cycle);
    for (int i = 1; i < tx_times.size(); i++) checkOutput("tx_spacing", tx_times[i] - tx_times[i-1], 2);

    $display("[TB] reversed print, reverse toggled mid-print");
    applyStimulus("11100000", 1'b1);
    reverse = 1'b0;
    waitDrain(100);

    $display("[TB] filtering and drops");
    applyStimulus("0a1\0150121100", 1'b0);
    injectDrop(8'h31);
    injectDrop(8'h30);
    injectDrop(8'h41);
    waitDrain(100);
    checkOutput("drop_total", drop_seen, exp_drops);

    $display("[TB] tx_busy backpressure");
    bp_en = 1'b1;
    applyStimulus("10011011", 1'b1);
    waitDrain(600);
    bp_en = 1'b0;
    repeat (25) @(posedge clk);

    $display("[TB] reset mid-collect and mid-print");
    applyStimulus("10110", 1'b0);
    doReset();
    applyStimulus("11001010", 1'b0);
    saved = tx_seen;
    n = 0;
    while (tx_seen < saved + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("three_tx_seen", tx_seen - saved, 3);
    doReset();
    saved = tx_seen;
    repeat (30) @(negedge clk);
    checkOutput("no_tx_after_rst", tx_seen, saved);
    applyStimulus("01101001", 1'b0);
    waitDrain(100);

    $display("[TB] single-bit instance");
    for (int k = 0; k < 2; k++) begin
      reverse1 = k[0];
      exp_tx1.push_back(k == 0 ? 8'h31 : 8'h30);
`ifdef BITSTR_CRLF_EN
      exp_tx1.push_back(8'h0D);
      exp_tx1.push_back(8'h0A);
`endif
      @(posedge clk); #1;
      rx_data1 = (k == 0) ? 8'h31 : 8'h30;
      new_rx_data1 = 1'b1;
      @(posedge clk); #1;
      new_rx_data1 = 1'b0;
      @(negedge clk);
      checkOutput("word1", word1, (k == 0) ? 1 : 0);
      checkOutput("state1_send", state1, 1);
      n = 0;
      while ((exp_tx1.size() != 0 || state1 != 2'd0) && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("tx1_left", exp_tx1.size(), 0);
      checkOutput("state1_idle", state1, 0);
      checkOutput("count1_idle", count1, 0);
    end

    checkOutput("words_left", exp_word.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
